scaler_tap_acc: RTL and testbench
=================================

SCALER_TAP_ACC -- requirements
Module: scaler_tap_acc

Interface
REQ-001 The module SHALL have parameter TAPS, default 4, giving the number of products summed per output; legal range 2..16.
REQ-002 The module SHALL have parameter FRAC, default 7, giving the coefficient fractional bits removed by rounding; legal range 1..14.
REQ-003 The module SHALL have parameter ACC_W, default 21, giving the accumulator width in bits (two's complement).
REQ-004 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port din_en, input, 1 bit: din_ab and din_db hold a valid product pair this cycle.
REQ-007 Port din_ab, input, 16 bits: signed product pixel_a*coef.
REQ-008 Port din_db, input, 16 bits: signed product pixel_d*coef.
REQ-009 Port din_sync, input, 1 bit: line/group restart pulse.
REQ-010 Port dout_en, output, 1 bit: dout_a, dout_d and dout_sat are valid this cycle (single-cycle pulse).
REQ-011 Port dout_a, output, 8 bits: signed rounded and saturated sum of din_ab.
REQ-012 Port dout_d, output, 8 bits: signed rounded and saturated sum of din_db.
REQ-013 Port dout_sat, output, 2 bits: bit1 set when dout_a clipped, bit0 set when dout_d clipped.
REQ-014 Port drop, output, 1 bit: one-cycle pulse when a partial group is discarded.

Function
REQ-015 The block SHALL have two states. IDLE means tap_cnt is 0 and no partial sum is held. ACCUM means 1 <= tap_cnt <= TAPS-1.
REQ-016 There is no backpressure. Every din_en cycle SHALL be consumed, and din_en may be deasserted for any number of cycles mid-group while tap_cnt and the accumulators hold.
REQ-017 On din_en in IDLE, acc_a and acc_d SHALL load the sign-extended din_ab and din_db, tap_cnt SHALL become 1, and the state SHALL move to ACCUM.
REQ-018 On din_en in ACCUM, acc_a and acc_d SHALL add the sign-extended inputs, and tap_cnt SHALL increment.
REQ-019 On the din_en that brings tap_cnt to TAPS, the completed sums SHALL be latched into the output stage, tap_cnt SHALL return to 0, and the state SHALL return to IDLE.
REQ-020 A new group may begin on the very next cycle, with no bubble required.
REQ-021 The output stage SHALL compute r = (sum + 2^(FRAC-1)) >>> FRAC, using an arithmetic shift so that halves round toward +inf.
REQ-022 The output stage SHALL clip r to the range -128..127, set the corresponding dout_sat bit when clipping occurs, and output the low 8 bits of the clipped value.
REQ-023 Latency SHALL be 2 cycles: dout_en asserts 2 clk after the rising edge that samples the last tap. Outputs SHALL hold their values between pulses.
REQ-024 Back-to-back groups (din_en continuously high) SHALL produce one dout_en pulse every TAPS cycles, with no loss.
REQ-025 When din_sync is seen in ACCUM, the block SHALL discard the partial sums, pulse drop for 1 cycle, and return to IDLE.
REQ-026 When din_sync is seen in IDLE, the block SHALL NOT pulse drop.
REQ-027 When din_sync and din_en coincide, the sync SHALL act first, and the sample SHALL become tap 0 of a new group.
REQ-028 din_sync SHALL NOT cancel a group already latched into the output stage; that group's dout_en SHALL still fire.
REQ-029 ACC_W SHALL hold TAPS*32768 without wrap. With ACC_W=21 there is no accumulator overflow for any input with TAPS<=16.

Reset
REQ-030 While rst_n is low, dout_en, dout_a, dout_d, dout_sat, drop, tap_cnt, acc_a, acc_d and the internal pipeline valid bits SHALL be 0, and the state SHALL be IDLE.
REQ-031 Reset asserted mid-group or mid-pipeline SHALL discard all in-flight data, and no dout_en SHALL appear for data sampled before reset.
REQ-032 After rst_n deasserts, the first din_en cycle SHALL be treated as tap 0.

Verification
REQ-033 Rounding scenario (TAPS=4, FRAC=7): 4 consecutive din_en with din_ab=64 and din_db=-1 -> dout_en 2 cycles after the 4th sample, dout_a=2, dout_d=0, dout_sat=00.
REQ-034 Saturation scenario: 4 taps with din_ab=16256 and din_db=-16384 -> dout_a=127 (0x7F), dout_d=-128 (0x80), dout_sat=11.
REQ-035 Gapped input scenario: 4 taps with din_ab=128 and din_db=384, separated by 3 idle cycles each -> exactly one dout_en, dout_a=4, dout_d=12.
REQ-036 Sync mid-group scenario: 2 taps, then din_sync together with din_en, then 3 more taps, all with din_ab=din_db=128 -> one drop pulse, then one dout_en with dout_a=dout_d=4.
REQ-037 Streaming scenario: 12 continuous din_en with din_ab=256 -> exactly 3 dout_en pulses spaced 4 cycles apart, each with dout_a=8.
REQ-038 Reset scenario: rst_n low for 1 cycle after the 3rd tap -> no dout_en pulse; the next 4 taps produce a normal result.

Source files
------------

// File: rtl/scaler_tap_acc.sv
// Polyphase scaler tap accumulator: sums TAPS signed products per channel, then rounds
// away FRAC fractional bits and saturates each channel to a signed 8-bit output.
module scaler_tap_acc #(
    parameter int unsigned TAPS  = 4,
    parameter int unsigned FRAC  = 7,
    parameter int unsigned ACC_W = 21
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din_en,
    input  logic [15:0] din_ab,
    input  logic [15:0] din_db,
    input  logic        din_sync,
    output logic        dout_en,
    output logic [7:0]  dout_a,
    output logic [7:0]  dout_d,
    output logic [1:0]  dout_sat,
    output logic        drop
);

    localparam int unsigned CntW = $clog2(TAPS);
    localparam int unsigned RndW = ACC_W + 1;

    localparam logic [CntW-1:0]        LastTap = CntW'(TAPS - 1);
    localparam logic signed [RndW-1:0] RndBias = RndW'(1) << (FRAC - 1);
    localparam logic signed [RndW-1:0] MaxV    = RndW'(127);
    localparam logic signed [RndW-1:0] MinV    = ~RndW'(127);

    typedef enum logic [0:0] {
        StIdle,
        StAccum
    } state_e;

    state_e                   state_q,    state_d;
    logic [CntW-1:0]          tap_cnt_q,  tap_cnt_d;
    logic signed [ACC_W-1:0]  acc_a_q,    acc_a_d;
    logic signed [ACC_W-1:0]  acc_d_q,    acc_d_d;
    logic                     drop_q,     drop_d;

    logic                     sum_vld_q,  sum_vld_d;
    logic signed [ACC_W-1:0]  sum_a_q,    sum_a_d;
    logic signed [ACC_W-1:0]  sum_d_q,    sum_d_d;

    logic                     rnd_vld_q;
    logic signed [RndW-1:0]   rnd_a_q,    rnd_a_d;
    logic signed [RndW-1:0]   rnd_d_q,    rnd_d_d;

    logic                     dout_en_q;
    logic [7:0]               dout_a_q,   dout_a_d;
    logic [7:0]               dout_d_q,   dout_d_d;
    logic [1:0]               dout_sat_q, dout_sat_d;

    logic signed [ACC_W-1:0]  ext_a, ext_d;
    logic                     restart;

    assign ext_a = {{(ACC_W - 16){din_ab[15]}}, din_ab};
    assign ext_d = {{(ACC_W - 16){din_db[15]}}, din_db};

    // Sync acts before the coincident sample, so that sample always opens a fresh group.
    assign restart = din_sync || (state_q == StIdle);

    always_comb begin
        state_d   = state_q;
        tap_cnt_d = tap_cnt_q;
        acc_a_d   = acc_a_q;
        acc_d_d   = acc_d_q;
        drop_d    = 1'b0;
        sum_vld_d = 1'b0;
        sum_a_d   = sum_a_q;
        sum_d_d   = sum_d_q;

        if (din_sync) begin
            drop_d    = (state_q == StAccum);
            state_d   = StIdle;
            tap_cnt_d = '0;
            acc_a_d   = '0;
            acc_d_d   = '0;
        end

        if (din_en) begin
            if (restart) begin
                acc_a_d   = ext_a;
                acc_d_d   = ext_d;
                tap_cnt_d = CntW'(1);
                state_d   = StAccum;
            end else if (tap_cnt_q == LastTap) begin
                sum_a_d   = acc_a_q + ext_a;
                sum_d_d   = acc_d_q + ext_d;
                sum_vld_d = 1'b1;
                acc_a_d   = '0;
                acc_d_d   = '0;
                tap_cnt_d = '0;
                state_d   = StIdle;
            end else begin
                acc_a_d   = acc_a_q + ext_a;
                acc_d_d   = acc_d_q + ext_d;
                tap_cnt_d = tap_cnt_q + CntW'(1);
            end
        end
    end

    // One guard bit keeps the rounding bias from wrapping a near-full-scale sum.
    always_comb begin
        logic signed [RndW-1:0] biased_a, biased_d;
        biased_a = $signed({sum_a_q[ACC_W-1], sum_a_q}) + RndBias;
        biased_d = $signed({sum_d_q[ACC_W-1], sum_d_q}) + RndBias;
        rnd_a_d  = rnd_a_q;
        rnd_d_d  = rnd_d_q;
        if (sum_vld_q) begin
            rnd_a_d = biased_a >>> FRAC;
            rnd_d_d = biased_d >>> FRAC;
        end
    end

    always_comb begin
        dout_a_d   = dout_a_q;
        dout_d_d   = dout_d_q;
        dout_sat_d = dout_sat_q;
        if (rnd_vld_q) begin
            if (rnd_a_q > MaxV) begin
                dout_a_d      = 8'h7F;
                dout_sat_d[1] = 1'b1;
            end else if (rnd_a_q < MinV) begin
                dout_a_d      = 8'h80;
                dout_sat_d[1] = 1'b1;
            end else begin
                dout_a_d      = rnd_a_q[7:0];
                dout_sat_d[1] = 1'b0;
            end
            if (rnd_d_q > MaxV) begin
                dout_d_d      = 8'h7F;
                dout_sat_d[0] = 1'b1;
            end else if (rnd_d_q < MinV) begin
                dout_d_d      = 8'h80;
                dout_sat_d[0] = 1'b1;
            end else begin
                dout_d_d      = rnd_d_q[7:0];
                dout_sat_d[0] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            tap_cnt_q  <= '0;
            acc_a_q    <= '0;
            acc_d_q    <= '0;
            drop_q     <= 1'b0;
            sum_vld_q  <= 1'b0;
            sum_a_q    <= '0;
            sum_d_q    <= '0;
            rnd_vld_q  <= 1'b0;
            rnd_a_q    <= '0;
            rnd_d_q    <= '0;
            dout_en_q  <= 1'b0;
            dout_a_q   <= '0;
            dout_d_q   <= '0;
            dout_sat_q <= '0;
        end else begin
            state_q    <= state_d;
            tap_cnt_q  <= tap_cnt_d;
            acc_a_q    <= acc_a_d;
            acc_d_q    <= acc_d_d;
            drop_q     <= drop_d;
            sum_vld_q  <= sum_vld_d;
            sum_a_q    <= sum_a_d;
            sum_d_q    <= sum_d_d;
            rnd_vld_q  <= sum_vld_q;
            rnd_a_q    <= rnd_a_d;
            rnd_d_q    <= rnd_d_d;
            dout_en_q  <= rnd_vld_q;
            dout_a_q   <= dout_a_d;
            dout_d_q   <= dout_d_d;
            dout_sat_q <= dout_sat_d;
        end
    end

    assign dout_en  = dout_en_q;
    assign dout_a   = dout_a_q;
    assign dout_d   = dout_d_q;
    assign dout_sat = dout_sat_q;
    assign drop     = drop_q;

endmodule

// File: tb/tb_scaler_tap_acc.sv
// Directed bench for scaler_tap_acc (TAPS=4, FRAC=7): hand-computed results per scenario.
module tb_scaler_tap_acc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din_en = 1'b0;
    logic [15:0] din_ab = '0;
    logic [15:0] din_db = '0;
    logic        din_sync = 1'b0;
    logic        dout_en;
    logic [7:0]  dout_a;
    logic [7:0]  dout_d;
    logic [1:0]  dout_sat;
    logic        drop;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int pulses   = 0;
    int drops    = 0;
    int pulse_cyc [64];
    int p0, d0, last_tap;

    scaler_tap_acc #(
        .TAPS (4),
        .FRAC (7),
        .ACC_W(21)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .din_en  (din_en),
        .din_ab  (din_ab),
        .din_db  (din_db),
        .din_sync(din_sync),
        .dout_en (dout_en),
        .dout_a  (dout_a),
        .dout_d  (dout_d),
        .dout_sat(dout_sat),
        .drop    (drop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dout_en) begin
            if (pulses < 64) pulse_cyc[pulses] <= cyc;
            pulses <= pulses + 1;
        end
        if (drop) drops <= drops + 1;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [15:0] a, input logic [15:0] d,
                         input logic sync);
        din_en   = en;
        din_ab   = a;
        din_db   = d;
        din_sync = sync;
        tick();
        din_en   = 1'b0;
        din_sync = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    endtask

    task automatic mark();
        p0 = pulses;
        d0 = drops;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check_eq("rst_dout_en", int'(dout_en), 0);
        check_eq("rst_dout_a", int'(dout_a), 0);
        check_eq("rst_dout_d", int'(dout_d), 0);
        check_eq("rst_dout_sat", int'(dout_sat), 0);
        check_eq("rst_drop", int'(drop), 0);
        rst_n = 1'b1;
        idle(2);

        // Rounding: 4*64=256 -> (256+64)>>>7=2 ; 4*-1=-4 -> (60)>>>7=0
        mark();
        for (int i = 0; i < 4; i++) drive(1'b1, 16'd64, 16'hFFFF, 1'b0);
        last_tap = cyc;
        idle(6);
        check_eq("rnd_pulses", pulses - p0, 1);
        check_eq("rnd_latency", pulse_cyc[p0] - last_tap, 2);
        check_eq("rnd_dout_a", int'(dout_a), 2);
        check_eq("rnd_dout_d", int'(dout_d), 0);
        check_eq("rnd_sat", int'(dout_sat), 0);
        check_eq("rnd_dout_en_low", int'(dout_en), 0);

        // Saturation: 65024 -> 508 clips to 0x7F ; -65536 -> -512 clips to 0x80
        mark();
        for (int i = 0; i < 4; i++) drive(1'b1, 16'd16256, 16'hC000, 1'b0);
        idle(6);
        check_eq("sat_pulses", pulses - p0, 1);
        check_eq("sat_dout_a", int'(dout_a), 8'h7F);
        check_eq("sat_dout_d", int'(dout_d), 8'h80);
        check_eq("sat_bits", int'(dout_sat), 3);

        // Gapped input: 512 -> 4 ; 1536 -> 12
        mark();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'd128, 16'd384, 1'b0);
            if (i < 3) idle(3);
        end
        last_tap = cyc;
        idle(6);
        check_eq("gap_pulses", pulses - p0, 1);
        check_eq("gap_latency", pulse_cyc[p0] - last_tap, 2);
        check_eq("gap_dout_a", int'(dout_a), 4);
        check_eq("gap_dout_d", int'(dout_d), 12);
        check_eq("gap_sat", int'(dout_sat), 0);

        // Sync while idle must not drop
        mark();
        drive(1'b0, 16'h0000, 16'h0000, 1'b1);
        idle(3);
        check_eq("sync_idle_drop", drops - d0, 0);

        // Sync mid-group with coincident sample starting a new group
        mark();
        drive(1'b1, 16'd128, 16'd128, 1'b0);
        drive(1'b1, 16'd128, 16'd128, 1'b0);
        drive(1'b1, 16'd128, 16'd128, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b1, 16'd128, 16'd128, 1'b0);
        idle(6);
        check_eq("sync_drops", drops - d0, 1);
        check_eq("sync_pulses", pulses - p0, 1);
        check_eq("sync_dout_a", int'(dout_a), 4);
        check_eq("sync_dout_d", int'(dout_d), 4);

        // Streaming: 12 back-to-back samples of 256 -> three results of 8
        mark();
        for (int i = 0; i < 12; i++) drive(1'b1, 16'd256, 16'd256, 1'b0);
        idle(6);
        check_eq("stream_pulses", pulses - p0, 3);
        check_eq("stream_gap0", pulse_cyc[p0 + 1] - pulse_cyc[p0], 4);
        check_eq("stream_gap1", pulse_cyc[p0 + 2] - pulse_cyc[p0 + 1], 4);
        check_eq("stream_dout_a", int'(dout_a), 8);

        // Sync right after a completed group leaves that group intact
        mark();
        for (int i = 0; i < 4; i++) drive(1'b1, 16'd384, 16'd128, 1'b0);
        drive(1'b0, 16'h0000, 16'h0000, 1'b1);
        idle(6);
        check_eq("sync_post_pulses", pulses - p0, 1);
        check_eq("sync_post_drops", drops - d0, 0);
        check_eq("sync_post_dout_a", int'(dout_a), 12);

        // Reset after 3 taps: nothing emerges, next group is clean
        mark();
        for (int i = 0; i < 3; i++) drive(1'b1, 16'd256, 16'd256, 1'b0);
        rst_n = 1'b0;
        tick();
        check_eq("rst_mid_dout_a", int'(dout_a), 0);
        rst_n = 1'b1;
        idle(6);
        check_eq("rst_mid_pulses", pulses - p0, 0);
        mark();
        for (int i = 0; i < 4; i++) drive(1'b1, 16'd256, 16'd128, 1'b0);
        idle(6);
        check_eq("rst_next_pulses", pulses - p0, 1);
        check_eq("rst_next_dout_a", int'(dout_a), 8);
        check_eq("rst_next_dout_d", int'(dout_d), 4);

        // Reset while a completed group is in the pipeline
        mark();
        for (int i = 0; i < 4; i++) drive(1'b1, 16'd256, 16'd256, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        idle(6);
        check_eq("rst_pipe_pulses", pulses - p0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
